// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int NUM_CORES  = 4;
    localparam int PERF_CNT_W = 16;

    typedef logic [1:0] core_id_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR_LO    = 3'd3,
        ST_WR_HI    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Core-side request/ack bus shared by all cores and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CORES  = dmem_arb_pkg::NUM_CORES
) ();

    logic [NUM_CORES-1:0]              req;
    logic [NUM_CORES-1:0]              we;
    logic [NUM_CORES*ADDR_WIDTH-1:0]   addr;
    logic [NUM_CORES*2*DATA_WIDTH-1:0] wdata;
    logic [NUM_CORES-1:0]              ack;
    logic [DATA_WIDTH-1:0]             rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_pick
// Description : Combinational rotate-priority picker; the core after last_gnt
//               has highest priority, last_gnt itself has lowest.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  wire [3:0] req,
    input  wire [1:0] last_gnt,
    output logic      valid,
    output core_id_t  id
);

    core_id_t w_idx;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        id    = last_gnt;
        w_idx = last_gnt;
        for (int k = 4; k >= 1; k--) begin
            w_idx = last_gnt + 2'(k);
            if (req[w_idx]) begin
                valid = 1'b1;
                id    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter/sequencer sharing one byte-wide memory
//               port among four cores; 16-bit writes split into two bytes.
//               Optional counters enabled by DMEM_ARBITER_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CORES  = 4
) (
    input  wire                    clk,
    input  wire                    rst_n,
    dmem_arbiter_if.slave          core_bus,
    output logic                   busy,
    output logic [1:0]             gnt_id,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  wire  [DATA_WIDTH-1:0]  mem_rdata
`ifdef DMEM_ARBITER_PERF_EN
    ,
    output logic [NUM_CORES*dmem_arb_pkg::PERF_CNT_W-1:0] perf_gnt_cnt,
    output logic [7:0]                                    perf_wait_max
`endif
);

    import dmem_arb_pkg::*;

    state_t                  r_state, w_state_nxt;
    core_id_t                r_id;
    core_id_t                r_last_gnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2*DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [NUM_CORES-1:0]    w_ack;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_pick_valid;
    core_id_t                w_pick_id;
    logic                    w_take;

    dmem_rr_pick u_pick (
        .req      (core_bus.req),
        .last_gnt (r_last_gnt),
        .valid    (w_pick_valid),
        .id       (w_pick_id)
    );

    assign w_take = (r_state == ST_IDLE) && w_pick_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_id       <= '0;
            r_last_gnt <= 2'd3;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_id    <= w_pick_id;
                r_addr  <= core_bus.addr[w_pick_id*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= core_bus.wdata[w_pick_id*2*DATA_WIDTH +: 2*DATA_WIDTH];
            end
            if (r_state == ST_RD_DATA)
                r_rdata <= mem_rdata;
            if ((r_state == ST_RD_DATA) || (r_state == ST_WR_HI))
                r_last_gnt <= r_id;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = '0;
        w_rdata     = r_rdata;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid)
                    w_state_nxt = core_bus.we[w_pick_id] ? ST_WR_LO : ST_RD_ISSUE;
            end
            ST_RD_ISSUE: begin
                mem_re      = 1'b1;
                mem_addr    = r_addr;
                w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                w_ack[r_id] = 1'b1;
                w_rdata     = mem_rdata;
                w_state_nxt = ST_IDLE;
            end
            ST_WR_LO: begin
                mem_we      = 1'b1;
                mem_addr    = r_addr;
                mem_wdata   = r_wdata[DATA_WIDTH-1:0];
                w_state_nxt = ST_WR_HI;
            end
            ST_WR_HI: begin
                mem_we      = 1'b1;
                mem_addr    = r_addr + ADDR_WIDTH'(1);
                mem_wdata   = r_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
                w_ack[r_id] = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign core_bus.ack   = w_ack;
    assign core_bus.rdata = w_rdata;
    assign busy           = (r_state != ST_IDLE);
    assign gnt_id         = r_id;

`ifdef DMEM_ARBITER_PERF_EN
    logic [7:0] w_wait [NUM_CORES];
    logic [7:0] r_wait_max;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_perf
        logic [PERF_CNT_W-1:0] r_gnt_cnt;
        logic [7:0]            r_wait;
        logic                  w_served;

        // A core being latched or already in service is not waiting.
        assign w_served = (w_take && (w_pick_id == core_id_t'(g))) ||
                          (busy && (r_id == core_id_t'(g)));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_gnt_cnt <= '0;
                r_wait    <= '0;
            end else begin
                if (w_ack[g] && (r_gnt_cnt != '1))
                    r_gnt_cnt <= r_gnt_cnt + 1'b1;
                if (!core_bus.req[g] || w_served)
                    r_wait <= '0;
                else if (r_wait != 8'hFF)
                    r_wait <= r_wait + 8'd1;
            end
        end

        assign w_wait[g] = r_wait;
        assign perf_gnt_cnt[g*PERF_CNT_W +: PERF_CNT_W] = r_gnt_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wait_max <= '0;
        else if (w_take && (w_wait[w_pick_id] > r_wait_max))
            r_wait_max <= w_wait[w_pick_id];
    end

    assign perf_wait_max = r_wait_max;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port, byte-wide data memory between the four multiplier cores.
- Takes per-core read/write requests, serialises them, and splits each 16-bit write into two byte writes: low byte at addr, high byte at addr+1.
- Drives the memory's single port and returns one-cycle acks plus read data to the cores.
- Sits between the core array and the data memory in the multi-core top level.

Parameters:
- DATA_WIDTH, 8, memory byte width; write data per core is 2*DATA_WIDTH.
- ADDR_WIDTH, 8, memory address width.
- NUM_CORES, 4, number of requesters; fixed at 4 in this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-core request; held until ack.
- we  input  4  per-core write flag; 1=write, 0=read; stable while req=1.
- addr  input  4*ADDR_WIDTH  per-core address; core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  input  4*2*DATA_WIDTH  per-core 16-bit write data; core i at [i*16 +: 16].
- ack  output  4  one-hot, one-cycle completion pulse.
- rdata  output  DATA_WIDTH  read data broadcast; valid only with a read ack.
- busy  output  1  high in any state other than IDLE.
- gnt_id  output  2  index of the core currently being served.
- mem_we  output  1  memory write enable.
- mem_re  output  1  memory read enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory byte write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid 1 cycle after mem_re.

Behaviour:
- States: IDLE, RD_ISSUE, RD_DATA, WR_LO, WR_HI.
- Reset (async, rst_n=0):
  - state=IDLE, last_gnt=3 (core 0 gets first priority), gnt_id=0.
  - ack=0, busy=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, rdata=0.
- IDLE:
  - If req!=0, pick the first requesting core in order last_gnt+1, +2, +3, +4 (mod 4).
  - Latch its id, we, addr and wdata into internal registers.
  - Go to WR_LO if we=1, else RD_ISSUE. Memory outputs stay idle in IDLE.
- RD_ISSUE: mem_re=1, mem_addr=latched addr; go to RD_DATA.
- RD_DATA: ack[id]=1, rdata=mem_rdata, last_gnt=id; go to IDLE.
- WR_LO: mem_we=1, mem_addr=addr, mem_wdata=wdata[7:0]; go to WR_HI.
- WR_HI:
  - mem_we=1, mem_addr=addr+1 (wraps mod 2^ADDR_WIDTH; 0xFF+1=0x00), mem_wdata=wdata[15:8].
  - ack[id]=1, last_gnt=id; go to IDLE.
- Latency from req sampled in IDLE to ack: read = 3 cycles, write = 3 cycles. Peak throughput is one transaction per 3 cycles.
- Handshake:
  - A core holds req/we/addr/wdata stable until it sees its ack.
  - req still high in the cycle after ack is treated as a new request and is arbitrated fresh, so that core goes to lowest priority.
- Requests arriving while busy wait. Inputs are sampled only in IDLE, so no request is lost while req is held.
- If req drops before ack (protocol violation), the latched transaction completes and is still acked.
- mem_we and mem_re are never high together. ack is never multi-hot.
- rdata holds its last value outside RD_DATA.
- Reset during WR_HI or after WR_LO aborts immediately. The low byte may already be written and no ack is issued; the core must retry.

Optional Feature:
- Macro DMEM_ARBITER_PERF_EN.
- Defined:
  - Adds output perf_gnt_cnt (4*16): per-core 16-bit completed-transaction counters.
  - A counter increments on its core's ack and saturates at 0xFFFF.
  - Adds output perf_wait_max (8): the maximum number of cycles any req waited in IDLE-eligible state before being latched, saturating at 0xFF.
  - All counters clear on reset.
- Undefined: these ports and their counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, RD_ISSUE, RD_DATA, WR_LO, WR_HI);
  - NUM_CORES=4;
  - core id type (2-bit);
  - PERF_CNT_W=16.
- One sub-module, dmem_rr_pick: combinational rotate-priority picker. Inputs req[3:0] and last_gnt[1:0]; outputs valid and id[1:0].
- The FSM and datapath registers live in dmem_arbiter.

Test Plan:
- Single write: core2 req, we=1, addr=0x10, wdata=0xA55A -> mem write 0x5A@0x10 then 0xA5@0x11 on consecutive cycles; ack[2] in WR_HI, 3 cycles after IDLE sample.
- Single read: core0 read addr=0x0F, model returns 0x07 -> mem_re 1 cycle, then ack[0] with rdata=0x07 the next cycle.
- Contention: all four req after reset -> grant order 0,1,2,3; with core0 re-requesting immediately, order continues 0,1,2,3,0 with no starvation.
- Wrap-around write: addr=0xFF, wdata=0x1234 -> 0x34@0xFF, 0x12@0x00.
- Reset mid-write: assert rst_n=0 in WR_HI -> mem_we=0 and ack=0 at once; after release, state IDLE and core0 has first priority.
- With DMEM_ARBITER_PERF_EN: 5 transactions by core1 -> perf_gnt_cnt[31:16]=5; core3 held off by 3 competitors -> perf_wait_max>=6.
